// File: rtl/adc_pipe_corr.sv
// Digital-correction back end for a pipelined ADC: decodes staggered thermometer
// stage codes, aligns them, sums them with weighted overlap and clamps the result.
module adc_pipe_corr #(
  parameter int NSTAGE    = 4,
  parameter int THERM_W   = 6,
  parameter int STAGE_B   = 3,
  parameter int SHIFT     = 2,
  parameter int OUT_W     = 8,
  parameter int DEC_MODE  = 0,
  parameter int ERR_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [NSTAGE*THERM_W-1:0]   therm_in,
  input  logic                        err_clr,
  output logic                        out_valid,
  output logic [OUT_W-1:0]            out_data,
  output logic                        out_err,
  output logic                        out_ovf,
  output logic [ERR_CNT_W-1:0]        err_cnt
);

  localparam int CNT_W   = $clog2(THERM_W + 1);
  localparam int SUM_RAW = STAGE_B + (NSTAGE - 1) * SHIFT + $clog2(NSTAGE) + 1;
  localparam int SUM_W   = (SUM_RAW > OUT_W + 1) ? SUM_RAW : OUT_W + 1;
  localparam logic [CNT_W-1:0] MAX_CODE = CNT_W'(THERM_W - 1);

  logic [NSTAGE*STAGE_B-1:0] algn_code;
  logic [NSTAGE-1:0]         algn_ill;
  logic                      valid_algn;

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
      localparam int DEPTH = NSTAGE - 1 - gi;
      logic [THERM_W-1:0] therm_w;
      logic [CNT_W-1:0]   ones_c;
      logic               bad_c;
      logic [STAGE_B-1:0] code_c;

      assign therm_w = therm_in[gi*THERM_W +: THERM_W];

      // A one above a zero is the only way a pattern can be illegal.
      always_comb begin
        ones_c = '0;
        bad_c  = 1'b0;
        for (int i = 0; i < THERM_W; i++)
          ones_c = ones_c + CNT_W'(therm_w[i]);
        for (int i = 1; i < THERM_W; i++)
          if (therm_w[i] && !therm_w[i-1]) bad_c = 1'b1;
        if (ones_c > MAX_CODE) ones_c = MAX_CODE;
        if (bad_c && DEC_MODE == 0) ones_c = MAX_CODE;
        code_c = STAGE_B'(ones_c);
      end

      if (DEPTH == 0) begin : g_direct
        assign algn_code[gi*STAGE_B +: STAGE_B] = code_c;
        assign algn_ill[gi] = bad_c;
      end else begin : g_dly
        logic [STAGE_B:0] dly_reg [DEPTH];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) dly_reg[i] <= '0;
          end else begin
            dly_reg[0] <= {bad_c, code_c};
            for (int i = 1; i < DEPTH; i++) dly_reg[i] <= dly_reg[i-1];
          end
        end
        assign {algn_ill[gi], algn_code[gi*STAGE_B +: STAGE_B]} = dly_reg[DEPTH-1];
      end
    end

    if (NSTAGE == 1) begin : g_vld_direct
      assign valid_algn = in_valid;
    end else begin : g_vld_pipe
      logic [NSTAGE-2:0] vld_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_reg <= '0;
        end else begin
          vld_reg[0] <= in_valid;
          for (int i = 1; i < NSTAGE - 1; i++) vld_reg[i] <= vld_reg[i-1];
        end
      end
      assign valid_algn = vld_reg[NSTAGE-2];
    end
  endgenerate

  logic [SUM_W-1:0] sum_c;
  logic             ovf_c;
  logic [OUT_W-1:0] data_c;

  // True weighted addition: overlapping bits carry instead of being OR-ed.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NSTAGE; k++)
      sum_c = sum_c + (SUM_W'(algn_code[k*STAGE_B +: STAGE_B]) << ((NSTAGE - 1 - k) * SHIFT));
    ovf_c  = |sum_c[SUM_W-1:OUT_W];
    data_c = ovf_c ? {OUT_W{1'b1}} : sum_c[OUT_W-1:0];
  end

  logic err_event;
  assign err_event = out_valid && out_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      out_ovf   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      out_valid <= valid_algn;
      if (valid_algn) begin
        out_data <= data_c;
        out_err  <= |algn_ill;
        out_ovf  <= ovf_c;
      end
      // A clear that lands on a counted event keeps that event.
      if (err_clr)
        err_cnt <= err_event ? ERR_CNT_W'(1) : '0;
      else if (err_event && err_cnt != {ERR_CNT_W{1'b1}})
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_adc_pipe_corr.sv
// Directed bench for adc_pipe_corr: default, popcount-decode, narrow-counter
// and single-stage instances share one stimulus stream.
module tb_adc_pipe_corr;

  localparam int NS = 4;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rst_n, in_valid, err_clr;
  logic [NS*TW-1:0] therm_in;

  logic d_valid, d_err, d_ovf;  logic [7:0] d_data;  logic [15:0] d_cnt;
  logic p_valid, p_err, p_ovf;  logic [7:0] p_data;  logic [15:0] p_cnt;
  logic e_valid, e_err, e_ovf;  logic [7:0] e_data;  logic [3:0]  e_cnt;
  logic n_valid, n_err, n_ovf;  logic [7:0] n_data;  logic [15:0] n_cnt;

  always #5 clk = ~clk;

  adc_pipe_corr dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .therm_in(therm_in), .err_clr(err_clr),
    .out_valid(d_valid), .out_data(d_data), .out_err(d_err), .out_ovf(d_ovf), .err_cnt(d_cnt));

  adc_pipe_corr #(.DEC_MODE(1)) dut_pop (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .therm_in(therm_in), .err_clr(err_clr),
    .out_valid(p_valid), .out_data(p_data), .out_err(p_err), .out_ovf(p_ovf), .err_cnt(p_cnt));

  adc_pipe_corr #(.ERR_CNT_W(4)) dut_e4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .therm_in(therm_in), .err_clr(err_clr),
    .out_valid(e_valid), .out_data(e_data), .out_err(e_err), .out_ovf(e_ovf), .err_cnt(e_cnt));

  adc_pipe_corr #(.NSTAGE(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .therm_in(therm_in[TW-1:0]), .err_clr(err_clr),
    .out_valid(n_valid), .out_data(n_data), .out_err(n_err), .out_ovf(n_ovf), .err_cnt(n_cnt));

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] pat [0:31][0:NS-1];
  logic [7:0] cap_data [0:63];
  logic       cap_err  [0:63];
  logic       cap_ovf  [0:63];
  int         cap_cyc  [0:63];
  int         nv;
  logic [7:0] pcap_data [0:63];
  logic       pcap_err  [0:63];
  int         npv;
  logic [7:0] ncap_data [0:63];
  int         ncap_cyc  [0:63];
  int         nnv;

  function automatic logic [TW-1:0] th(input int code);
    th = TW'((1 << code) - 1);
  endfunction

  task automatic clear_pat();
    for (int s = 0; s < 32; s++)
      for (int k = 0; k < NS; k++) pat[s][k] = '0;
  endtask

  // Sample s puts stage k on the bus in cycle s+k; in_valid marks stage 0.
  task automatic run_stream(input int n, input int clr_c);
    nv = 0; npv = 0; nnv = 0;
    for (int c = 0; c < n + NS + 2; c++) begin
      in_valid = (c < n);
      err_clr  = (c == clr_c);
      for (int k = 0; k < NS; k++) begin
        if (c - k >= 0 && c - k < n) therm_in[k*TW +: TW] = pat[c-k][k];
        else                         therm_in[k*TW +: TW] = '0;
      end
      @(posedge clk); #1;
      if (d_valid) begin
        $display("out %0d: cyc=%0d data=%0d err=%0b ovf=%0b cnt=%0d", nv, c, d_data, d_err, d_ovf, d_cnt);
        cap_data[nv] = d_data; cap_err[nv] = d_err; cap_ovf[nv] = d_ovf; cap_cyc[nv] = c;
        nv++;
      end
      if (p_valid) begin
        pcap_data[npv] = p_data; pcap_err[npv] = p_err; npv++;
      end
      if (n_valid) begin
        ncap_data[nnv] = n_data; ncap_cyc[nnv] = c; nnv++;
      end
    end
    in_valid = 1'b0; err_clr = 1'b0; therm_in = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0; therm_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({d_valid, d_data, d_err, d_ovf, d_cnt} !== 27'd0) begin
      $display("FAIL reset_state got v=%0b d=%0d e=%0b o=%0b c=%0d want all 0", d_valid, d_data, d_err, d_ovf, d_cnt);
      errors++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_pat();
    pat[0][0] = th(1); pat[0][1] = th(2); pat[0][2] = th(3); pat[0][3] = th(4);
    run_stream(1, -1);
    checks++;
    if (nv !== 1) begin $display("FAIL basic_count got %0d want 1", nv); errors++; end
    else begin
      checks++;
      if (cap_cyc[0] !== 3) begin $display("FAIL basic_latency got %0d want 3", cap_cyc[0]); errors++; end
      checks++;
      if ({cap_data[0], cap_err[0], cap_ovf[0]} !== {8'd112, 1'b0, 1'b0}) begin
        $display("FAIL basic_data got %0d/%0b/%0b want 112/0/0", cap_data[0], cap_err[0], cap_ovf[0]);
        errors++;
      end
    end
    checks++;
    if (nnv !== 1 || ncap_cyc[0] !== 0 || ncap_data[0] !== 8'd1) begin
      $display("FAIL nstage1 got n=%0d cyc=%0d data=%0d want 1/0/1", nnv, ncap_cyc[0], ncap_data[0]);
      errors++;
    end
  endtask

  task automatic test_ovf();
    logic [7:0] exp_d [0:3];
    logic       exp_o [0:3];
    clear_pat();
    pat[0][0] = th(3); pat[0][1] = th(5); pat[0][2] = th(5); pat[0][3] = th(5);
    pat[2][0] = th(3); pat[2][1] = th(3); pat[2][2] = th(3); pat[2][3] = th(3);
    pat[3][3] = th(6);
    exp_d[0] = 8'd255; exp_o[0] = 1'b1;
    exp_d[1] = 8'd0;   exp_o[1] = 1'b0;
    exp_d[2] = 8'd255; exp_o[2] = 1'b0;
    exp_d[3] = 8'd5;   exp_o[3] = 1'b0;
    run_stream(4, -1);
    checks++;
    if (nv !== 4) begin $display("FAIL ovf_count got %0d want 4", nv); errors++; end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({cap_data[i], cap_ovf[i], cap_err[i]} !== {exp_d[i], exp_o[i], 1'b0}) begin
          $display("FAIL ovf_sample%0d got %0d/ovf%0b/err%0b want %0d/ovf%0b/err0",
                   i, cap_data[i], cap_ovf[i], cap_err[i], exp_d[i], exp_o[i]);
          errors++;
        end
      end
    end
  endtask

  task automatic test_illegal();
    clear_pat();
    pat[0][1] = 6'b000101;
    run_stream(1, -1);
    checks++;
    if (nv !== 1 || cap_data[0] !== 8'd80 || cap_err[0] !== 1'b1) begin
      $display("FAIL illegal_exact got n=%0d data=%0d err=%0b want 1/80/1", nv, cap_data[0], cap_err[0]);
      errors++;
    end
    checks++;
    if (npv !== 1 || pcap_data[0] !== 8'd32 || pcap_err[0] !== 1'b1) begin
      $display("FAIL illegal_pop got n=%0d data=%0d err=%0b want 1/32/1", npv, pcap_data[0], pcap_err[0]);
      errors++;
    end
    checks++;
    if (d_cnt !== 16'd1) begin $display("FAIL illegal_errcnt got %0d want 1", d_cnt); errors++; end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [0:7];
    clear_pat();
    for (int s = 0; s < 8; s++) pat[s][0] = th(s % 6);
    exp_d[0] = 8'd0;   exp_d[1] = 8'd64;  exp_d[2] = 8'd128; exp_d[3] = 8'd192;
    exp_d[4] = 8'd255; exp_d[5] = 8'd255; exp_d[6] = 8'd0;   exp_d[7] = 8'd64;
    run_stream(8, -1);
    checks++;
    if (nv !== 8) begin $display("FAIL b2b_count got %0d want 8", nv); errors++; end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (cap_cyc[i] !== i + 3 || cap_data[i] !== exp_d[i] || cap_ovf[i] !== (i == 4 || i == 5)) begin
          $display("FAIL b2b_sample%0d got cyc=%0d data=%0d ovf=%0b want cyc=%0d data=%0d ovf=%0b",
                   i, cap_cyc[i], cap_data[i], cap_ovf[i], i + 3, exp_d[i], (i == 4 || i == 5));
          errors++;
        end
      end
    end
    checks++;
    if (d_valid !== 1'b0 || d_data !== 8'd64) begin
      $display("FAIL hold got v=%0b data=%0d want 0/64", d_valid, d_data);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    int stray;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      therm_in = '0;
      therm_in[TW-1:0] = th(2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; therm_in = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({d_valid, d_data, d_err, d_ovf, d_cnt} !== 27'd0) begin
      $display("FAIL async_reset got v=%0b d=%0d e=%0b o=%0b c=%0d want all 0", d_valid, d_data, d_err, d_ovf, d_cnt);
      errors++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (d_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin $display("FAIL flushed_valid got %0d want 0", stray); errors++; end
    clear_pat();
    pat[0][0] = th(1); pat[0][1] = th(2); pat[0][2] = th(3); pat[0][3] = th(4);
    run_stream(1, -1);
    checks++;
    if (nv !== 1 || cap_cyc[0] !== 3 || cap_data[0] !== 8'd112) begin
      $display("FAIL post_reset got n=%0d cyc=%0d data=%0d want 1/3/112", nv, cap_cyc[0], cap_data[0]);
      errors++;
    end
  endtask

  task automatic test_err_sat();
    clear_pat();
    for (int s = 0; s < 20; s++) pat[s][1] = 6'b000101;
    run_stream(20, -1);
    checks++;
    if (e_cnt !== 4'd15) begin $display("FAIL errcnt_sat got %0d want 15", e_cnt); errors++; end
    checks++;
    if (d_cnt !== 16'd20) begin $display("FAIL errcnt_wide got %0d want 20", d_cnt); errors++; end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (e_cnt !== 4'd15) begin $display("FAIL errcnt_hold got %0d want 15", e_cnt); errors++; end
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    checks++;
    if (e_cnt !== 4'd0) begin $display("FAIL errclr_plain got %0d want 0", e_cnt); errors++; end
    clear_pat();
    pat[0][1] = 6'b000101;
    run_stream(1, 4);
    checks++;
    if (e_cnt !== 4'd1 || d_cnt !== 16'd1) begin
      $display("FAIL errclr_event got e4=%0d wide=%0d want 1/1", e_cnt, d_cnt);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    test_err_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_pipe_corr.md
Name: adc_pipe_corr

Overview:
Parametrised digital-correction back end for a multi-stage pipelined ADC, one clock domain.
Decodes NSTAGE thermometer stage codes to binary and time-aligns stages that arrive staggered by one cycle each.
Combines the stages by true weighted addition with overlap, rather than by OR-ing the overlap bits, and clamps the result to the output width.
Adds bubble tolerance, per-sample error/overflow flags, a sticky error counter and a valid handshake; feeds the sample output path.

Parameters:
NSTAGE, 4, number of thermometer stages (1..8); stage 0 carries the highest weight
THERM_W, 6, thermometer width per stage; decoded code range 0..THERM_W-1
STAGE_B, 3, binary width per decoded stage; 2^STAGE_B >= THERM_W required
SHIFT, 2, weight step between adjacent stages in bits (STAGE_B-1 gives one bit of overlap)
OUT_W, 8, corrected output width
DEC_MODE, 0, 0 = exact-match decode, 1 = popcount (bubble-tolerant) decode
ERR_CNT_W, 16, width of the error counter

Ports:
clk  in  1  sample clock; everything in this block is on its rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  stage-0 data of a new sample is present this cycle
therm_in  in  NSTAGE*THERM_W  stage k at [k*THERM_W +: THERM_W], LSB-filled thermometer
err_clr  in  1  synchronous clear of err_cnt
out_valid  out  1  out_data/out_err/out_ovf hold a corrected sample
out_data  out  OUT_W  corrected code
out_err  out  1  at least one stage of this sample was not a legal thermometer pattern
out_ovf  out  1  sum exceeded 2^OUT_W-1 and was clamped
err_cnt  out  ERR_CNT_W  saturating count of samples with out_err=1

Behaviour:
- Reset (rst_n=0, asynchronous): all delay pipes, valid pipe, out_valid, out_data, out_err, out_ovf and err_cnt go to 0 immediately. Samples in flight are discarded; no out_valid is emitted for them after release.
- Timing of one sample: stage 0 arrives in cycle t (in_valid=1); stage k arrives in cycle t+k. Stages other than stage 0 have no valid qualifier.
- Alignment: the decoded stage k passes through NSTAGE-1-k free-running registers. A valid shift register of depth NSTAGE-1 tracks in_valid.
- Output register: loads in cycle t+NSTAGE-1, so out_valid=1 during cycle t+NSTAGE. Latency is NSTAGE clocks. Back-to-back in_valid on every cycle is supported at full rate; out_valid is a 1-cycle pulse per sample.
- Legal thermometer: 0 or more ones packed at the LSB, none above them (THERM_W+1 patterns). All-ones is legal and decodes to THERM_W-1, i.e. it saturates.
- DEC_MODE=0: a legal pattern decodes to min(ones, THERM_W-1); any illegal pattern decodes to THERM_W-1.
- DEC_MODE=1: decode to min(popcount, THERM_W-1) for any pattern.
- Illegal flag: in both modes an illegal pattern sets that stage's illegal flag. The flag travels with the stage through alignment; out_err = OR of the NSTAGE flags of the sample.
- Sum: code_k << ((NSTAGE-1-k)*SHIFT) summed over k in an internal width wide enough for no wrap. If sum > 2^OUT_W-1, out_data = all ones and out_ovf=1; otherwise out_data = sum and out_ovf=0.
- Holding: out_data/out_err/out_ovf hold their last value while out_valid=0.
- err_cnt: increments by 1 on each cycle with out_valid=1 and out_err=1; saturates at 2^ERR_CNT_W-1 with no wrap.
- err_clr: clears err_cnt. If err_clr coincides with a counted event, err_cnt becomes 1 so the event is not lost.
- NSTAGE=1: no alignment registers; latency is 1.

Test Plan:
Defaults (weights 64,16,4,1). Codes 1,2,3,4 (000001, 000011, 000111, 001111) applied at t0..t3 with in_valid at t0 -> out_valid at t4, out_data=112, out_err=0, out_ovf=0.
Codes 3,5,5,5 -> sum 297 -> out_data=255, out_ovf=1. All stages 000000 -> out_data=0, out_ovf=0.
Stage 1 = 000101, others 0: DEC_MODE=0 -> out_data=80, out_err=1, err_cnt=1; DEC_MODE=1 -> out_data=32, out_err=1.
8 samples with in_valid high every cycle, stage-0 codes 0..5,0,1, other stages 0 -> 8 consecutive out_valid cycles with out_data 0,64,128,192,255(ovf),255(ovf),0,64.
rst_n pulsed low for 1 cycle while 3 samples are in flight -> outputs 0 asynchronously; no out_valid after release until a new in_valid plus 4 cycles.
ERR_CNT_W=4: 20 erroneous samples -> err_cnt=15 and holds; err_clr on a cycle with an error output -> err_cnt=1.
